// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
//   lsu_state_t : FSM state encoding
//   BYTE_LANES  : byte lanes per 32-bit RAM word
//   lane_mask() : one-hot byte enable for a byte address offset
package lsu_pkg;

  typedef enum logic [2:0] {IDLE, RD, WAIT, WB, WR, ERR} lsu_state_t;

  localparam int BYTE_LANES = 4;

  function automatic logic [BYTE_LANES-1:0] lane_mask(input logic [1:0] lane);
    return BYTE_LANES'(1) << lane;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational load formatter.
//   word     in  32  raw RAM word
//   lane     in   2  byte offset of the access (lane 0 = bits 7:0)
//   is_byte  in   1  byte access; otherwise the word passes through
//   sign_ext in   1  sign-extend the selected byte instead of zero-extending
//   data     out 32  value for the register file
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic        is_byte,
  input  logic        sign_ext,
  output logic [31:0] data
);

  logic [BYTE_LANES-1:0][7:0] lanes;
  logic [7:0]                 sel;

  always_comb begin
    lanes = word;
    sel   = lanes[lane];
    data  = is_byte ? {{24{sign_ext & sel[7]}}, sel} : word;
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-side engine for LDR/STR/LDRB/STRB.
// Optional build macro: LSU_SIGN_EXT_EN adds ld_signed (LDRSB sign extension).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             request pulse, sampled only in IDLE
//   is_load, is_byte  access kind
//   addr, str_data    byte address and store data from the datapath
//   rd_addr           load destination register
//   ld_signed         (LSU_SIGN_EXT_EN only) sign-extend byte loads
//   mem_*             data RAM interface (word address, byte enables, strobes)
//   w_*_ldr           load write-back port to the datapath
//   busy, done, err   status; err pulses together with done on misalignment
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W     = 11,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_load,
  input  logic              is_byte,
  input  logic [31:0]       addr,
  input  logic [31:0]       str_data,
  input  logic [3:0]        rd_addr,
`ifdef LSU_SIGN_EXT_EN
  input  logic              ld_signed,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_byteen,
  output logic              mem_wren,
  output logic              mem_rden,
  input  logic [31:0]       mem_rdata,
  output logic [3:0]        w_addr_ldr,
  output logic              w_en_ldr,
  output logic [31:0]       w_data_ldr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  lsu_state_t  state;
  logic [1:0]  cnt;
  logic        is_byte_q;
  logic [1:0]  lane_q;
  logic [3:0]  rd_q;
  logic        sign_q;
  logic [31:0] ld_data;

  // Address bits above the RAM space are dropped so accesses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

`ifdef LSU_SIGN_EXT_EN
  always_ff @(posedge clk) begin
    if (rst)                         sign_q <= 1'b0;
    else if (state == IDLE && start) sign_q <= ld_signed;
  end
`else
  assign sign_q = 1'b0;
`endif

  // Format straight off the RAM port so the write-back value is registered
  // in the same edge that captures the read data.
  lsu_load_align u_align (
    .word     (mem_rdata),
    .lane     (lane_q),
    .is_byte  (is_byte_q),
    .sign_ext (sign_q),
    .data     (ld_data)
  );

  assign busy = (state != IDLE);

  // Outputs are registered on entry to the state that owns them, so every
  // strobe lines up with its state and lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      is_byte_q  <= 1'b0;
      lane_q     <= '0;
      rd_q       <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_byteen <= '0;
      mem_wren   <= 1'b0;
      mem_rden   <= 1'b0;
      w_addr_ldr <= '0;
      w_en_ldr   <= 1'b0;
      w_data_ldr <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      mem_wdata  <= '0;
      mem_byteen <= '0;
      mem_wren   <= 1'b0;
      mem_rden   <= 1'b0;
      w_addr_ldr <= '0;
      w_en_ldr   <= 1'b0;
      w_data_ldr <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      case (state)
        IDLE: if (start) begin
          is_byte_q <= is_byte;
          lane_q    <= addr[1:0];
          rd_q      <= rd_addr;
          mem_addr  <= addr[ADDR_W+1:2];
          if (!is_byte && addr[1:0] != 2'b00) begin
            state <= ERR;
            err   <= 1'b1;
            done  <= 1'b1;
          end else if (is_load) begin
            state    <= RD;
            mem_rden <= 1'b1;
            cnt      <= 2'(RD_LATENCY - 1);
          end else begin
            state      <= WR;
            mem_wren   <= 1'b1;
            done       <= 1'b1;
            mem_byteen <= is_byte ? lane_mask(addr[1:0]) : 4'hF;
            mem_wdata  <= is_byte ? {4{str_data[7:0]}} : str_data;
          end
        end
        RD: state <= WAIT;
        WAIT: begin
          if (cnt == 2'd0) begin
            state      <= WB;
            w_en_ldr   <= 1'b1;
            done       <= 1'b1;
            w_addr_ldr <= rd_q;
            w_data_ldr <= ld_data;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: begin  // WB, WR, ERR: single-cycle states
          state    <= IDLE;
          mem_addr <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-side engine for LDR/STR/LDRB/STRB.
- Sits between the CPU controller's memory/memory_wait states and the data RAM.
- Takes the effective address (datapath_out) and store data (str_data) from the datapath.
- For loads, returns the read value to the datapath's load write port (w_addr_ldr / w_en_ldr / w_data_ldr).
- Handles byte lanes, fixed RAM read latency, misalignment detection and a done handshake back to the controller.

Parameters:
- ADDR_W, 11: word-address width of the data RAM (2048 x 32).
- RD_LATENCY, 1: cycles from mem_rden to valid mem_rdata; legal range 1..4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request pulse from the controller; sampled only in IDLE
- is_load  in  1  1 = LDR/LDRB, 0 = STR/STRB
- is_byte  in  1  1 = byte access, 0 = word access
- addr  in  32  byte address (datapath_out)
- str_data  in  32  store data (datapath str_data)
- rd_addr  in  4  destination register for loads
- mem_addr  out  ADDR_W  word address = addr[ADDR_W+1:2]
- mem_wdata  out  32  write data to RAM
- mem_byteen  out  4  byte enables
- mem_wren  out  1  RAM write strobe
- mem_rden  out  1  RAM read strobe
- mem_rdata  in  32  RAM read data
- w_addr_ldr  out  4  load destination register to the datapath
- w_en_ldr  out  1  load write enable to the datapath (one-cycle pulse)
- w_data_ldr  out  32  load write data to the datapath
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle misalignment pulse; coincides with done

Behaviour:
- Reset: state IDLE. All outputs 0 and the wait counter cleared. Reset mid-operation abandons the access with no write-back and no done.
- FSM states:
  - IDLE: on start, latch is_load, is_byte, addr, str_data and rd_addr.
  - IDLE transitions: if !is_byte and addr[1:0] != 0, go to ERR; else if is_load go to RD; else go to WR.
  - WR (1 cycle): mem_wren=1, done=1; then IDLE.
  - RD (1 cycle): mem_rden=1; counter loaded with RD_LATENCY-1; then WAIT.
  - WAIT: count down. When the counter is 0, capture mem_rdata into a data register; then WB.
  - WB (1 cycle): w_en_ldr=1, done=1, w_addr_ldr = latched rd_addr, w_data_ldr = formatted data; then IDLE.
  - ERR (1 cycle): err=1, done=1; no RAM access and no write-back; then IDLE.
- mem_addr is driven from the latched addr in all non-IDLE states, and is 0 in IDLE.
- Store formatting:
  - Word: mem_byteen=4'hF, mem_wdata=str_data.
  - Byte: mem_byteen = 4'b0001 << addr[1:0], mem_wdata = {4{str_data[7:0]}}.
- Load formatting:
  - Word: w_data_ldr = captured word.
  - Byte: lane addr[1:0] (lane 0 = bits 7:0, little-endian), zero-extended to 32 bits.
- w_data_ldr and w_addr_ldr are 0 outside WB.
- mem_byteen is 0 when mem_wren is 0.
- Latency measured from the cycle start is sampled:
  - Store: done 1 cycle later.
  - Error: done 1 cycle later.
  - Load: done 2+RD_LATENCY cycles later (3 at the default).
- start while busy is ignored; no queueing.
- A start in the same cycle as done (state not yet IDLE) is also ignored; the controller must re-pulse it.
- addr bits above ADDR_W+1 are ignored; wrap within RAM space.
- Simultaneous rst and start: rst wins.

Optional Feature:
- Macro: LSU_SIGN_EXT_EN.
- Defined: adds input port ld_signed (1 bit), latched with start. Byte loads with ld_signed=1 sign-extend bit 7 of the selected lane (LDRSB); word loads are unaffected.
- Undefined: port absent; byte loads always zero-extend.

Decomposition:
- Package lsu_pkg holds:
  - typedef enum logic [2:0] lsu_state_t {IDLE, RD, WAIT, WB, WR, ERR}
  - localparam BYTE_LANES = 4
  - function lane_mask(logic [1:0]) returning a 4-bit byte enable
- One sub-module, lsu_load_align: combinational lane select plus zero/sign extension of the captured word.

Test Plan:
- Word store: start, is_load=0, is_byte=0, addr=0x10, str_data=0xDEADBEEF -> next cycle mem_wren=1, mem_addr=4, mem_byteen=4'hF, mem_wdata=0xDEADBEEF, done=1; then idle.
- Byte store: addr=0x13, str_data=0x000000A5 -> mem_byteen=4'b1000, mem_wdata=0xA5A5A5A5, mem_addr=4.
- Word load, RD_LATENCY=1: RAM word 4 = 0x12345678, addr=0x10, rd_addr=7 -> mem_rden 1 cycle after start; w_en_ldr=1, w_addr_ldr=7, w_data_ldr=0x12345678, done=1 exactly 3 cycles after start.
- Byte load: RAM word 4 = 0x80FF7F01, addr=0x12 -> w_data_ldr=0x000000FF. With LSU_SIGN_EXT_EN and ld_signed=1 -> 0xFFFFFFFF. addr=0x11 with ld_signed=1 -> 0x0000007F.
- Misaligned word load: addr=0x0E, is_byte=0 -> err=1 and done=1 one cycle later; mem_rden, mem_wren and w_en_ldr never asserted.
- Busy and reset: second start during WAIT is ignored (exactly one done); rst asserted in WAIT -> no w_en_ldr, busy=0 the cycle after; RD_LATENCY=3 run gives done at cycle 5.
